tick_period_meter: RTL

//   Receive-side counterpart of the tick prescaler. It measures the number of clk_in cycles

---
 rtl/timer_pkg.sv | 13 +
 rtl/sync_rise_detect.sv | 27 ++
 rtl/tick_period_meter.sv | 118 +++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer subsystem: FSM state encoding and default widths.
// Both the tick prescaler and the period meter use these.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meter_state_e;

    localparam int unsigned TICK_WIDTH = 16;

endpackage

// File: rtl/sync_rise_detect.sv
// Synchronizes an asynchronous input into clk_in and flags its rising edges.
// This runs continuously; only reset clears it.
module sync_rise_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic evt_in,
    output logic evt_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], evt_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign evt_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures clk_in cycles between successive rising edges of evt_in.
// Each period is delivered through a single-entry valid/ready result register.
module tick_period_meter
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH       = TICK_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             evt_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [WIDTH-1:0] meas_period,
    output logic             meas_ovf,
    output logic             meas_lost,
    output logic             busy
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    meter_state_e     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_int_q, ovf_int_d;
    logic             capture;
    logic             evt_rise;
    logic             xfer;

    logic             valid_q;
    logic [WIDTH-1:0] period_q;
    logic             ovf_q;
    logic             lost_q;

    sync_rise_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_rise (
        .clk_in  (clk_in),
        .rst     (rst),
        .evt_in  (evt_in),
        .evt_rise(evt_rise)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovf_int_d = ovf_int_q;
        capture   = 1'b0;
        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            ovf_int_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (evt_rise) begin
                        cnt_d   = WIDTH'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (evt_rise) begin
                        // Back-to-back periods: the closing edge opens the next one.
                        capture   = 1'b1;
                        cnt_d     = WIDTH'(1);
                        ovf_int_d = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_int_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_int_q <= ovf_int_d;
        end
    end

    assign xfer = valid_q & meas_ready;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            valid_q  <= 1'b0;
            period_q <= '0;
            ovf_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else if (capture) begin
            valid_q  <= 1'b1;
            period_q <= cnt_q;
            ovf_q    <= ovf_int_q;
            lost_q   <= valid_q & ~xfer;
        end else begin
            lost_q <= 1'b0;
            if (xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign meas_valid  = valid_q;
    assign meas_period = period_q;
    assign meas_ovf    = ovf_q;
    assign meas_lost   = lost_q;
    assign busy        = (state_q != IDLE);

endmodule
